// File: rtl/spram_pkg.sv
// Shared defaults and clear-sequencer state type for the single-port RAM slice.
// The clear sequencer exists only when SPRAM_CLEAR_ON_RESET_EN is defined.
package spram_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  // Power is usable only with the supply up and ground actually grounded.
  function automatic logic pwr_good(input logic vdd, input logic gnd);
    return vdd & ~gnd;
  endfunction

endpackage

// File: rtl/spram_65536x8_if.sv
// Access bus of the single-port RAM: address/data, active-low strobes, supply flags, busy.
interface spram_if #(
  parameter int ADDR_W = spram_pkg::ADDR_W_DEF,
  parameter int DATA_W = spram_pkg::DATA_W_DEF
);

  logic [ADDR_W-1:0] ADR;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
  logic              ENB;
  logic              WEB;
  logic              OEB;
  logic              ramvdd;
  logic              ramgnd;
  logic              BUSY;

  modport master (
    output ADR, D, ENB, WEB, OEB, ramvdd, ramgnd,
    input  Q, BUSY
  );

  modport slave (
    input  ADR, D, ENB, WEB, OEB, ramvdd, ramgnd,
    output Q, BUSY
  );

endinterface

// File: rtl/spram_clear_seq.sv
// Zero-fill sequencer (SPRAM_CLEAR_ON_RESET_EN): one word per cycle, 2**ADDR_W cycles after reset.
// Latency: busy drops one cycle after the last word is written; backpressure: none, callers see busy.
`ifdef SPRAM_CLEAR_ON_RESET_EN
module spram_clear_seq
  import spram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_adr
);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= READY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The counter doubles as the fill address; writing while busy is the whole job.
  assign clr_we  = busy;
  assign clr_adr = cnt;

endmodule
`endif

// File: rtl/spram_65536x8.sv
// Single-port RAM, write-first, 1-cycle registered read, combinational output enable.
// Latency: 1 cycle; backpressure: none except BUSY during optional SPRAM_CLEAR_ON_RESET_EN clear.
module spram_65536x8
  import spram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic   CLK,
  input logic   RST,
  spram_if.slave bus
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              pwr_ok;
  logic              busy;
  logic              usr_acc;
  logic              usr_wr;
  logic              usr_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] q_reg;

  assign pwr_ok  = pwr_good(bus.ramvdd, bus.ramgnd);
  assign usr_acc = ~RST & ~busy & pwr_ok & ~bus.ENB;
  assign usr_wr  = usr_acc & ~bus.WEB;
  assign usr_rd  = usr_acc &  bus.WEB;

`ifdef SPRAM_CLEAR_ON_RESET_EN
  logic              clr_we;
  logic [ADDR_W-1:0] clr_adr;

  spram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk     (CLK),
    .rst     (RST),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_adr (clr_adr)
  );

  // User writes are blocked while busy, so the clear owns the port outright.
  assign mem_we   = usr_wr | clr_we;
  assign mem_adr  = clr_we ? clr_adr : bus.ADR;
  assign mem_wdat = clr_we ? '0 : bus.D;
`else
  assign busy     = 1'b0;
  assign mem_we   = usr_wr;
  assign mem_adr  = bus.ADR;
  assign mem_wdat = bus.D;
`endif

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_adr] <= mem_wdat;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else if (usr_wr) begin
      q_reg <= bus.D;
    end else if (usr_rd) begin
      q_reg <= mem[bus.ADR];
    end
  end

  assign bus.Q    = (~bus.OEB & pwr_ok & ~busy) ? q_reg : '0;
  assign bus.BUSY = busy;

endmodule

// File: tb/tb_spram_65536x8.sv
// Directed checks of spram_65536x8; the clear section needs SPRAM_CLEAR_ON_RESET_EN.
module tb_spram_65536x8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spram_if bus ();

  spram_65536x8 dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus.ENB = 1'b0;
    bus.WEB = ~wr;
    bus.ADR = a;
    bus.D   = d;
    tick();
    bus.ENB = 1'b1;
    bus.WEB = 1'b1;
  endtask

`ifdef SPRAM_CLEAR_ON_RESET_EN
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (bus.BUSY === 1'b1 && n < 70000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd65536);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    bus.ENB    = 1'b1;
    bus.WEB    = 1'b1;
    bus.OEB    = 1'b0;
    bus.ramvdd = 1'b1;
    bus.ramgnd = 1'b0;
    bus.ADR    = '0;
    bus.D      = '0;
    tick();
    tick();
    chk("rst_q", 32'(bus.Q), 32'h00);
`ifdef SPRAM_CLEAR_ON_RESET_EN
    chk("rst_busy", 32'(bus.BUSY), 32'd1);
    rst = 1'b0;
    count_busy("clr_len_init");
`else
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    rst = 1'b0;
`endif

    // Write-first then registered read
    acc(1'b1, 16'h1234, 8'hA5);
    chk("wr_first", 32'(bus.Q), 32'hA5);
    acc(1'b1, 16'h0001, 8'h3C);
    chk("wr_first2", 32'(bus.Q), 32'h3C);
    acc(1'b0, 16'h1234, 8'h00);
    chk("rd_1234", 32'(bus.Q), 32'hA5);

    // Output enable is combinational
    bus.OEB = 1'b1;
    #1 chk("oeb_off", 32'(bus.Q), 32'h00);
    bus.OEB = 1'b0;
    #1 chk("oeb_on", 32'(bus.Q), 32'hA5);

    // Disabled write must not land
    bus.ENB = 1'b1;
    bus.WEB = 1'b0;
    bus.ADR = 16'h1234;
    bus.D   = 8'h5A;
    tick();
    bus.WEB = 1'b1;
    chk("enb_hold", 32'(bus.Q), 32'hA5);
    acc(1'b0, 16'h0001, 8'h00);
    chk("rd_0001", 32'(bus.Q), 32'h3C);
    acc(1'b0, 16'h1234, 8'h00);
    chk("enb_nowr", 32'(bus.Q), 32'hA5);

    // Power loss: no write, Q forced low, register held
    bus.ramvdd = 1'b0;
    #1 chk("pwr_q", 32'(bus.Q), 32'h00);
    acc(1'b1, 16'h1234, 8'h77);
    chk("pwr_q_wr", 32'(bus.Q), 32'h00);
    bus.ramvdd = 1'b1;
    #1 chk("pwr_hold", 32'(bus.Q), 32'hA5);
    bus.ramgnd = 1'b1;
    #1 chk("gnd_q", 32'(bus.Q), 32'h00);
    bus.ramgnd = 1'b0;
    acc(1'b0, 16'h0001, 8'h00);
    acc(1'b0, 16'h1234, 8'h00);
    chk("pwr_nowr", 32'(bus.Q), 32'hA5);

    // Address boundaries and write-then-read on consecutive cycles
    acc(1'b1, 16'h00FF, 8'h10);
    acc(1'b1, 16'h0000, 8'h11);
    acc(1'b1, 16'hFFFF, 8'h22);
    acc(1'b0, 16'h0000, 8'h00);
    chk("rd_0000", 32'(bus.Q), 32'h11);
    acc(1'b0, 16'hFFFF, 8'h00);
    chk("rd_ffff", 32'(bus.Q), 32'h22);
    acc(1'b1, 16'h00FF, 8'h99);
    acc(1'b0, 16'h00FF, 8'h00);
    chk("b2b_00ff", 32'(bus.Q), 32'h99);

    acc(1'b0, 16'h1234, 8'h00);
    chk("pre_rst", 32'(bus.Q), 32'hA5);

`ifdef SPRAM_CLEAR_ON_RESET_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("clr_busy", 32'(bus.BUSY), 32'd1);
    chk("clr_q", 32'(bus.Q), 32'h00);
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("clr_len_restart");
    acc(1'b0, 16'h1234, 8'h00);
    chk("clr_rd_1234", 32'(bus.Q), 32'h00);
`else
    // Access during reset is ignored; memory survives reset
    rst     = 1'b1;
    bus.ENB = 1'b0;
    bus.WEB = 1'b0;
    bus.ADR = 16'h1234;
    bus.D   = 8'hEE;
    tick();
    rst     = 1'b0;
    bus.ENB = 1'b1;
    bus.WEB = 1'b1;
    chk("rst_q2", 32'(bus.Q), 32'h00);
    acc(1'b0, 16'h1234, 8'h00);
    chk("rst_mem", 32'(bus.Q), 32'hA5);
    chk("busy_idle", 32'(bus.BUSY), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spram_65536x8.md
SPRAM_65536X8 -- requirements
Module: spram65536x8

Interface
- REQ-001 Parameter ADDR_W, default 16, sets the address width; depth is 2**ADDR_W words.
- REQ-002 Parameter DATA_W, default 8, sets the word width.
- REQ-003 Clocking is one clock, CLK; reset is RST, synchronous and active-high.
- REQ-004 Port CLK  input  1  sole clock; all state updates on its rising edge.
- REQ-005 Port RST  input  1  synchronous active-high reset.
- REQ-006 Port ADR  input  ADDR_W  word address.
- REQ-007 Port D  input  DATA_W  write data.
- REQ-008 Port Q  output  DATA_W  read data.
- REQ-009 Port ENB  input  1  chip enable, active-low.
- REQ-010 Port WEB  input  1  write enable, active-low; 1 = read.
- REQ-011 Port OEB  input  1  output enable, active-low.
- REQ-012 Port ramvdd  input  1  supply-good flag; 1 = powered.
- REQ-013 Port ramgnd  input  1  ground flag; 0 = grounded.
- REQ-014 Port BUSY  output  1  memory unavailable (clear in progress).

Function
- REQ-015 pwr_ok = ramvdd & ~ramgnd; with pwr_ok=0, no write or read occurs, the output register holds its value, and Q = 0.
- REQ-016 Access occurs on a CLK edge when RST=0, BUSY=0, pwr_ok=1 and ENB=0; with ENB=1, memory and the output register are unchanged.
- REQ-017 Write (WEB=0): mem[ADR] <= D; write-first, so the output register also loads D in the same edge.
- REQ-018 Read (WEB=1): output register <= mem[ADR]; read latency is 1 cycle (data valid after the capturing edge).
- REQ-019 Q = output register when OEB=0 and pwr_ok=1, else 0; OEB is combinational and has no latency.
- REQ-020 A read of an address in the cycle after a write to it returns the new data; back-to-back accesses are allowed every cycle.
- REQ-021 The address wraps naturally: ADR all-ones is a valid final word, with no out-of-range condition.
- REQ-022 Memory is uninitialised (X in simulation) unless cleared per REQ-026.

Reset
- REQ-023 While RST=1 on a CLK edge, the output register is set to 0; Q is therefore 0 once RST has been sampled.
- REQ-024 RST does not alter memory contents unless SPRAM_CLEAR_ON_RESET_EN is defined.
- REQ-025 Accesses presented in a cycle where RST=1 are ignored.

Configuration
- REQ-026 With SPRAM_CLEAR_ON_RESET_EN defined, a clear sequencer with states CLEAR and READY is compiled in:
  - RST=1 forces state CLEAR and counter 0.
  - After RST deasserts, each cycle writes 0 to mem[counter] and increments the counter.
  - After writing address 2**ADDR_W-1, the state goes to READY, one cycle after that write.
  - BUSY=1 in CLEAR; while BUSY=1, user accesses are ignored and Q = 0.
  - RST asserted mid-clear restarts the sequence from address 0.
  - Clearing takes exactly 2**ADDR_W cycles after RST deasserts.
- REQ-027 Without SPRAM_CLEAR_ON_RESET_EN, BUSY is tied to 0 and no sequencer logic exists.

Structure
- REQ-028 Package spram_pkg holds the ADDR_W/DATA_W defaults and the clear-state enum (CLEAR, READY).
- REQ-029 The clear sequencer is one sub-module, spram_clear_seq (inputs clk/rst; outputs busy, clr_we, clr_adr), instantiated only under the macro.
- REQ-030 Memory array, access decode, output register and Q gating live in the top module; the array infers a single-port RAM.

Verification
- REQ-031 Write/read: write 0xA5 to 0x1234, then read 0x1234 with OEB=0 -> Q=0xA5 one cycle after the read edge.
- REQ-032 Output enable: after REQ-031, set OEB=1 -> Q=0x00 at once; set OEB=0 -> Q=0xA5 with no new access.
- REQ-033 Disable and power: write 0x5A to 0x1234 with ENB=1 -> reading returns 0xA5; ramvdd=0 during a write of 0x77 -> the location is unchanged and Q=0.
- REQ-034 Boundaries: write 0x11 to 0x0000 and 0x22 to 0xFFFF, then read both -> 0x11 and 0x22; write then read 0x00FF on consecutive cycles -> new data returned.
- REQ-035 Reset: after a read leaves Q=0xA5, one cycle of RST=1 -> Q=0x00 and mem[0x1234] still reads 0xA5 (macro undefined).
- REQ-036 Clear (macro defined) -> with mem[0x1234]=0xA5 written, pulse RST:
  - BUSY stays 1 for 65536 cycles after RST deasserts.
  - Reading 0x1234 afterwards returns 0x00.
  - RST asserted at cycle 100 of the clear restarts the full 65536-cycle count.
